// File: rtl/score_line_formatter.sv
// Converts latched current/best scores to BCD with a serial double-dabble engine
// and streams one LCD row ("PTS:sss MAX:bbb ") as ASCII characters with DDRAM addresses.
module score_line_formatter #(
    parameter int         COLS     = 16,
    parameter logic [6:0] ROW_BASE = 7'h40,
    parameter bit         LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] score_i,
    input  logic [7:0] best_i,
    output logic [7:0] char_o,
    output logic [6:0] addr_o,
    output logic       char_valid_o,
    input  logic       char_ready_i,
    output logic       busy_o,
    output logic       done_o
);

    localparam int            CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV_S,
        CONV_B,
        EMIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    score_lat;
    logic [7:0]    best_lat;
    logic [7:0]    bin_sh;
    logic [7:0]    shift_src;
    logic [11:0]   score_bcd;
    logic [11:0]   best_bcd;
    logic [2:0]    shift_cnt;
    logic [CW-1:0] col;
    logic          xfer;
    logic [7:0]    char_sel;

    // One double-dabble step: correct every nibble >= 5, then shift in the next binary bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic bit_in);
        logic [11:0] adj;
        adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (adj[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
            end
        end
        return (adj << 1) | {11'b0, bit_in};
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
        return blank ? 8'h20 : (8'h30 + {4'h0, d});
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        char_valid_o = 1'b0;
        done_o       = 1'b0;
        busy_o       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = CONV_S;
                end
            end
            CONV_S: begin
                if (shift_cnt == 3'd7) begin
                    state_next = CONV_B;
                end
            end
            CONV_B: begin
                if (shift_cnt == 3'd7) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                char_valid_o = 1'b1;
                if (char_ready_i && (col == LAST_COL)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign xfer = (state == EMIT) && char_ready_i;

    // The first shift of each conversion takes its bits straight from the latched score,
    // so the latched values themselves are never modified while a line is in flight.
    always_comb begin
        shift_src = bin_sh;
        if (shift_cnt == 3'd0) begin
            if (state == CONV_S) begin
                shift_src = score_lat;
            end else if (state == CONV_B) begin
                shift_src = best_lat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_lat <= 8'h00;
            best_lat  <= 8'h00;
            bin_sh    <= 8'h00;
            score_bcd <= 12'h000;
            best_bcd  <= 12'h000;
            shift_cnt <= 3'd0;
            col       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        score_lat <= score_i;
                        best_lat  <= best_i;
                        score_bcd <= 12'h000;
                        best_bcd  <= 12'h000;
                        shift_cnt <= 3'd0;
                        col       <= '0;
                    end
                end
                CONV_S: begin
                    score_bcd <= dabble_step(score_bcd, shift_src[7]);
                    bin_sh    <= {shift_src[6:0], 1'b0};
                    shift_cnt <= shift_cnt + 3'd1;
                end
                CONV_B: begin
                    best_bcd  <= dabble_step(best_bcd, shift_src[7]);
                    bin_sh    <= {shift_src[6:0], 1'b0};
                    shift_cnt <= shift_cnt + 3'd1;
                end
                EMIT: begin
                    if (xfer && (col != LAST_COL)) begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking: tens is blanked only when hundreds is blanked too.
    always_comb begin
        char_sel = 8'h20;
        case (col)
            CW'(0):  char_sel = "P";
            CW'(1):  char_sel = "T";
            CW'(2):  char_sel = "S";
            CW'(3):  char_sel = ":";
            CW'(4):  char_sel = digit_char(score_bcd[11:8], LZ_BLANK && (score_bcd[11:8] == 4'h0));
            CW'(5):  char_sel = digit_char(score_bcd[7:4], LZ_BLANK && (score_bcd[11:4] == 8'h00));
            CW'(6):  char_sel = digit_char(score_bcd[3:0], 1'b0);
            CW'(8):  char_sel = "M";
            CW'(9):  char_sel = "A";
            CW'(10): char_sel = "X";
            CW'(11): char_sel = ":";
            CW'(12): char_sel = digit_char(best_bcd[11:8], LZ_BLANK && (best_bcd[11:8] == 4'h0));
            CW'(13): char_sel = digit_char(best_bcd[7:4], LZ_BLANK && (best_bcd[11:4] == 8'h00));
            CW'(14): char_sel = digit_char(best_bcd[3:0], 1'b0);
            default: char_sel = 8'h20;
        endcase
    end

    assign char_o = (state == EMIT) ? char_sel : 8'h00;
    assign addr_o = (state == EMIT) ? (ROW_BASE + 7'(col)) : 7'h00;

endmodule

// File: tb/tb_score_line_formatter.sv
// Randomized self-checking bench for score_line_formatter: each line is compared
// character by character against a text image built from the score values.
module tb_score_line_formatter;

    localparam int         COLS     = 16;
    localparam logic [6:0] ROW_BASE = 7'h40;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [7:0] score_i;
    logic [7:0] best_i;
    logic [7:0] char_o;
    logic [6:0] addr_o;
    logic       char_valid_o;
    logic       char_ready_i;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_line [COLS];

    score_line_formatter #(
        .COLS    (COLS),
        .ROW_BASE(ROW_BASE),
        .LZ_BLANK(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .score_i     (score_i),
        .best_i      (best_i),
        .char_o      (char_o),
        .addr_o      (addr_o),
        .char_valid_o(char_valid_o),
        .char_ready_i(char_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // A 3-digit field: hundreds only when value >= 100, tens only when value >= 10.
    task automatic putField(input int base, input int v);
        if (v >= 100) exp_line[base] = 8'(8'h30 + v / 100);
        if (v >= 10)  exp_line[base + 1] = 8'(8'h30 + (v / 10) % 10);
        exp_line[base + 2] = 8'(8'h30 + v % 10);
    endtask

    task automatic buildLine(input logic [7:0] s, input logic [7:0] b);
        string pts;
        string mx;
        pts = "PTS:";
        mx  = "MAX:";
        for (int i = 0; i < COLS; i++) exp_line[i] = 8'h20;
        for (int i = 0; i < 4; i++) begin
            exp_line[i]     = pts[i];
            exp_line[8 + i] = mx[i];
        end
        putField(4, int'(s));
        putField(12, int'(b));
    endtask

    // ready_mode: 0 = always ready, 1 = toggle 1/0, 2 = random.
    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] b, input int ready_mode,
                                 input bit poke, input int abort_col, input bit hold);
        int         cyc;
        int         idx;
        logic       rdy;
        logic [6:0] ea;
        buildLine(s, b);
        checkOutput("idle_busy_before_start", busy_o, 1'b0);
        score_i = s;
        best_i  = b;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = hold;
        cyc = 0;
        while (char_valid_o !== 1'b1 && cyc < 40) begin
            if (poke && cyc == 10) begin
                start_i = 1'b1;
                score_i = ~s;
                best_i  = ~b;
            end else begin
                start_i = hold;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("first_valid_latency", cyc, 16);
        idx = 0;
        cyc = 0;
        while (idx < COLS && cyc < 200) begin
            if (abort_col >= 0 && idx == abort_col) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                checkOutput("abort_char", char_o, 8'h00);
                checkOutput("abort_addr", addr_o, 7'h00);
                checkOutput("abort_valid", char_valid_o, 1'b0);
                checkOutput("abort_busy", busy_o, 1'b0);
                checkOutput("abort_done", done_o, 1'b0);
                return;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            char_ready_i = rdy;
            if (poke && idx == 5) begin
                start_i = 1'b1;
                score_i = 8'($urandom);
                best_i  = 8'($urandom);
            end else begin
                start_i = hold;
            end
            ea = ROW_BASE + 7'(idx);
            checkOutput($sformatf("valid_col%0d", idx), char_valid_o, 1'b1);
            checkOutput($sformatf("char_col%0d", idx), char_o, exp_line[idx]);
            checkOutput($sformatf("addr_col%0d", idx), addr_o, ea);
            checkOutput($sformatf("done_low_col%0d", idx), done_o, 1'b0);
            @(posedge clk); #1;
            cyc++;
            if (rdy) idx++;
        end
        checkOutput("emit_complete", idx, COLS);
        checkOutput("done_pulse", done_o, 1'b1);
        checkOutput("done_valid_low", char_valid_o, 1'b0);
        checkOutput("done_busy", busy_o, 1'b1);
        char_ready_i = 1'($urandom_range(0, 1));
        start_i = hold;
        @(posedge clk); #1;
        checkOutput("done_single_cycle", done_o, 1'b0);
        checkOutput("idle_after_done", busy_o, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        start_i      = 1'b0;
        score_i      = 8'h00;
        best_i       = 8'h00;
        char_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_char", char_o, 8'h00);
        checkOutput("reset_addr", addr_o, 7'h00);
        checkOutput("reset_valid", char_valid_o, 1'b0);
        checkOutput("reset_busy", busy_o, 1'b0);
        checkOutput("reset_done", done_o, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] zero scores, full rate");
        applyStimulus(8'd0, 8'd0, 0, 1'b0, -1, 1'b0);
        $display("[TB] maximum score");
        applyStimulus(8'd255, 8'd100, 0, 1'b0, -1, 1'b0);
        $display("[TB] toggled ready");
        applyStimulus(8'd7, 8'd40, 1, 1'b0, -1, 1'b0);
        $display("[TB] start pulses while busy");
        applyStimulus(8'($urandom), 8'($urandom), 2, 1'b1, -1, 1'b0);
        $display("[TB] reset mid-line then a fresh line");
        applyStimulus(8'd123, 8'd45, 0, 1'b0, 9, 1'b0);
        applyStimulus(8'd9, 8'd99, 0, 1'b0, -1, 1'b0);
        $display("[TB] start held high, back-to-back lines");
        applyStimulus(8'd10, 8'd200, 0, 1'b0, -1, 1'b1);
        applyStimulus(8'd1, 8'd250, 0, 1'b0, -1, 1'b1);
        applyStimulus(8'd99, 8'd100, 0, 1'b0, -1, 1'b1);
        start_i = 1'b0;
        @(posedge clk); #1;
        $display("[TB] randomized lines");
        for (int n = 0; n < 20; n++) begin
            applyStimulus(8'($urandom), 8'($urandom), 2, 1'b0, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
